// File: rtl/float_accumulator.sv
// Frame accumulator for the FPU float format (sign, unbiased two's-complement exponent,
// hidden-one mantissa); each term runs a fixed 4-cycle idle/align/add/normalize loop.
module float_accumulator #(
    parameter int unsigned EXP_W   = 8,
    parameter int unsigned MANT_W  = 23,
    parameter int unsigned N_TERMS = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W-1:0] in_mantis,
    output logic              out_valid,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_exp,
    output logic [MANT_W-1:0] out_mantis,
    output logic              out_zero,
    output logic              out_ovf
);

    localparam int unsigned SigW = MANT_W + 1;
    localparam int unsigned SumW = MANT_W + 2;
    localparam int unsigned ExtW = EXP_W + 1;
    localparam int unsigned LzW  = $clog2(SigW + 1);
    localparam int unsigned CntW = $clog2(N_TERMS + 1);

    localparam logic [CntW-1:0]  LastCnt  = CntW'(N_TERMS - 1);
    localparam logic [ExtW-1:0]  MaxShift = ExtW'(SigW);
    localparam logic [EXP_W-1:0] ExpMax   = {1'b0, {(EXP_W - 1){1'b1}}};

    typedef enum logic [1:0] {
        StIdle,
        StAlign,
        StAdd,
        StNorm
    } state_e;

    state_e state_q, state_d;

    // Captured input term
    logic              op_sign_q, op_sign_d;
    logic [EXP_W-1:0]  op_exp_q, op_exp_d;
    logic [MANT_W-1:0] op_mant_q, op_mant_d;

    // Running sum of the current frame
    logic              acc_sign_q, acc_sign_d;
    logic [EXP_W-1:0]  acc_exp_q, acc_exp_d;
    logic [MANT_W-1:0] acc_mant_q, acc_mant_d;
    logic              acc_zero_q, acc_zero_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              ovf_q, ovf_d;

    // Aligned operands (ALIGN -> ADD)
    logic              big_sign_q, big_sign_d;
    logic              small_sign_q, small_sign_d;
    logic [SigW-1:0]   big_sig_q, big_sig_d;
    logic [SigW-1:0]   small_sig_q, small_sig_d;
    logic [EXP_W-1:0]  e1_q, e1_d;

    // Raw sum (ADD -> NORM)
    logic [SumW-1:0]   sum_q, sum_d;
    logic              sum_sign_q, sum_sign_d;

    // Frame result registers
    logic              out_valid_q, out_valid_d;
    logic              out_sign_q, out_sign_d;
    logic [EXP_W-1:0]  out_exp_q, out_exp_d;
    logic [MANT_W-1:0] out_mant_q, out_mant_d;
    logic              out_zero_q, out_zero_d;
    logic              out_ovf_q, out_ovf_d;

    // ---------------- align datapath ----------------
    logic [ExtW-1:0] acc_ext, op_ext, exp_diff, shamt;
    logic            acc_big;
    logic [SigW-1:0] acc_sig, op_sig, small_pre, small_aligned;

    always_comb begin
        acc_ext   = {acc_exp_q[EXP_W-1], acc_exp_q};
        op_ext    = {op_exp_q[EXP_W-1], op_exp_q};
        exp_diff  = acc_ext - op_ext;
        acc_big   = ~exp_diff[ExtW-1];
        shamt     = acc_big ? exp_diff : (op_ext - acc_ext);
        acc_sig   = {1'b1, acc_mant_q};
        op_sig    = {1'b1, op_mant_q};
        small_pre = acc_big ? op_sig : acc_sig;
        // Anything shifted past the hidden one is gone entirely after truncation
        small_aligned = (shamt >= MaxShift) ? '0 : (small_pre >> shamt);
    end

    // ---------------- add datapath ----------------
    logic [SumW-1:0] add_sum;
    logic            add_sign;

    always_comb begin
        add_sum  = '0;
        add_sign = 1'b0;
        if (big_sign_q == small_sign_q) begin
            add_sum  = {1'b0, big_sig_q} + {1'b0, small_sig_q};
            add_sign = big_sign_q;
        end else if (big_sig_q > small_sig_q) begin
            add_sum  = {1'b0, big_sig_q - small_sig_q};
            add_sign = big_sign_q;
        end else if (big_sig_q < small_sig_q) begin
            add_sum  = {1'b0, small_sig_q - big_sig_q};
            add_sign = small_sign_q;
        end
    end

    // ---------------- normalize datapath ----------------
    logic [LzW-1:0]    lz;
    logic [MANT_W-1:0] norm_mant;
    logic [ExtW-1:0]   e1_ext, exp_wide;
    logic              res_zero, res_sign, res_ovf;
    logic [EXP_W-1:0]  res_exp;
    logic [MANT_W-1:0] res_mant;

    always_comb begin
        lz = LzW'(SigW);
        for (int i = 0; i < int'(SigW); i++) begin
            if (sum_q[i]) begin
                lz = LzW'(int'(SigW) - 1 - i);
            end
        end
    end

    always_comb begin
        e1_ext    = {e1_q[EXP_W-1], e1_q};
        norm_mant = MANT_W'(sum_q[MANT_W:0] << lz);
        exp_wide  = '0;
        res_zero  = 1'b0;
        res_sign  = sum_sign_q;
        res_ovf   = 1'b0;
        res_exp   = '0;
        res_mant  = '0;
        if (sum_q == '0) begin
            res_zero = 1'b1;
        end else begin
            if (sum_q[SumW-1]) begin
                exp_wide = e1_ext + ExtW'(1);
                res_mant = sum_q[MANT_W:1];
            end else begin
                exp_wide = e1_ext - ExtW'(lz);
                res_mant = norm_mant;
            end
            res_exp = exp_wide[EXP_W-1:0];
            // Top two bits 01: above max, 10: below min
            if (exp_wide[ExtW-1 -: 2] == 2'b01) begin
                res_ovf  = 1'b1;
                res_exp  = ExpMax;
                res_mant = '1;
            end else if (exp_wide[ExtW-1 -: 2] == 2'b10) begin
                res_zero = 1'b1;
            end
        end
        if (res_zero) begin
            res_sign = 1'b0;
            res_exp  = '0;
            res_mant = '0;
        end
    end

    // ---------------- control ----------------
    always_comb begin
        state_d      = state_q;
        op_sign_d    = op_sign_q;
        op_exp_d     = op_exp_q;
        op_mant_d    = op_mant_q;
        acc_sign_d   = acc_sign_q;
        acc_exp_d    = acc_exp_q;
        acc_mant_d   = acc_mant_q;
        acc_zero_d   = acc_zero_q;
        cnt_d        = cnt_q;
        ovf_d        = ovf_q;
        big_sign_d   = big_sign_q;
        small_sign_d = small_sign_q;
        big_sig_d    = big_sig_q;
        small_sig_d  = small_sig_q;
        e1_d         = e1_q;
        sum_d        = sum_q;
        sum_sign_d   = sum_sign_q;
        out_valid_d  = 1'b0;
        out_sign_d   = out_sign_q;
        out_exp_d    = out_exp_q;
        out_mant_d   = out_mant_q;
        out_zero_d   = out_zero_q;
        out_ovf_d    = out_ovf_q;
        in_ready     = (state_q == StIdle);

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    op_sign_d = in_sign;
                    op_exp_d  = in_exp;
                    op_mant_d = in_mantis;
                    state_d   = StAlign;
                end
            end
            StAlign: begin
                if (acc_zero_q) begin
                    big_sign_d   = op_sign_q;
                    small_sign_d = op_sign_q;
                    big_sig_d    = op_sig;
                    small_sig_d  = '0;
                    e1_d         = op_exp_q;
                end else if (acc_big) begin
                    big_sign_d   = acc_sign_q;
                    small_sign_d = op_sign_q;
                    big_sig_d    = acc_sig;
                    small_sig_d  = small_aligned;
                    e1_d         = acc_exp_q;
                end else begin
                    big_sign_d   = op_sign_q;
                    small_sign_d = acc_sign_q;
                    big_sig_d    = op_sig;
                    small_sig_d  = small_aligned;
                    e1_d         = op_exp_q;
                end
                state_d = StAdd;
            end
            StAdd: begin
                sum_d      = add_sum;
                sum_sign_d = add_sign;
                state_d    = StNorm;
            end
            StNorm: begin
                acc_sign_d = res_sign;
                acc_exp_d  = res_exp;
                acc_mant_d = res_mant;
                acc_zero_d = res_zero;
                cnt_d      = cnt_q + CntW'(1);
                ovf_d      = ovf_q | res_ovf;
                if (cnt_q == LastCnt) begin
                    out_valid_d = 1'b1;
                    out_sign_d  = res_sign;
                    out_exp_d   = res_exp;
                    out_mant_d  = res_mant;
                    out_zero_d  = res_zero;
                    out_ovf_d   = ovf_q | res_ovf;
                    acc_sign_d  = 1'b0;
                    acc_exp_d   = '0;
                    acc_mant_d  = '0;
                    acc_zero_d  = 1'b1;
                    cnt_d       = '0;
                    ovf_d       = 1'b0;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= StIdle;
            op_sign_q    <= 1'b0;
            op_exp_q     <= '0;
            op_mant_q    <= '0;
            acc_sign_q   <= 1'b0;
            acc_exp_q    <= '0;
            acc_mant_q   <= '0;
            acc_zero_q   <= 1'b1;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            big_sign_q   <= 1'b0;
            small_sign_q <= 1'b0;
            big_sig_q    <= '0;
            small_sig_q  <= '0;
            e1_q         <= '0;
            sum_q        <= '0;
            sum_sign_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_sign_q   <= 1'b0;
            out_exp_q    <= '0;
            out_mant_q   <= '0;
            out_zero_q   <= 1'b0;
            out_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_sign_q    <= op_sign_d;
            op_exp_q     <= op_exp_d;
            op_mant_q    <= op_mant_d;
            acc_sign_q   <= acc_sign_d;
            acc_exp_q    <= acc_exp_d;
            acc_mant_q   <= acc_mant_d;
            acc_zero_q   <= acc_zero_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            big_sign_q   <= big_sign_d;
            small_sign_q <= small_sign_d;
            big_sig_q    <= big_sig_d;
            small_sig_q  <= small_sig_d;
            e1_q         <= e1_d;
            sum_q        <= sum_d;
            sum_sign_q   <= sum_sign_d;
            out_valid_q  <= out_valid_d;
            out_sign_q   <= out_sign_d;
            out_exp_q    <= out_exp_d;
            out_mant_q   <= out_mant_d;
            out_zero_q   <= out_zero_d;
            out_ovf_q    <= out_ovf_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_sign   = out_sign_q;
    assign out_exp    = out_exp_q;
    assign out_mantis = out_mant_q;
    assign out_zero   = out_zero_q;
    assign out_ovf    = out_ovf_q;

endmodule

// File: tb/tb_float_accumulator.sv
// Scoreboard bench for float_accumulator: one instance with N_TERMS=4, one with N_TERMS=2.
module tb_float_accumulator;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        iv_a = 1'b0, is_a = 1'b0, rdy_a, ov_a, os_a, oz_a, oo_a;
    logic [7:0]  ie_a = '0, oe_a;
    logic [22:0] im_a = '0, om_a;
    logic        iv_b = 1'b0, is_b = 1'b0, rdy_b, ov_b, os_b, oz_b, oo_b;
    logic [7:0]  ie_b = '0, oe_b;
    logic [22:0] im_b = '0, om_b;

    float_accumulator #(.EXP_W(8), .MANT_W(23), .N_TERMS(4)) dut_a (
        .clk(clk), .rstn(rstn), .in_valid(iv_a), .in_ready(rdy_a), .in_sign(is_a),
        .in_exp(ie_a), .in_mantis(im_a), .out_valid(ov_a), .out_sign(os_a), .out_exp(oe_a),
        .out_mantis(om_a), .out_zero(oz_a), .out_ovf(oo_a)
    );

    float_accumulator #(.EXP_W(8), .MANT_W(23), .N_TERMS(2)) dut_b (
        .clk(clk), .rstn(rstn), .in_valid(iv_b), .in_ready(rdy_b), .in_sign(is_b),
        .in_exp(ie_b), .in_mantis(im_b), .out_valid(ov_b), .out_sign(os_b), .out_exp(oe_b),
        .out_mantis(om_b), .out_zero(oz_b), .out_ovf(oo_b)
    );

    // v packs {sign, exp[7:0], mantis[22:0]}
    typedef struct {
        logic [31:0] v;
        logic        z;
        logic        o;
        int          at;
    } exp_item_t;

    exp_item_t q_a[$];
    exp_item_t q_b[$];
    exp_item_t ea, eb;
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic push(input bit to_b, input logic [31:0] v, input logic z, input logic o,
                        input int at);
        exp_item_t it;
        it.v  = v;
        it.z  = z;
        it.o  = o;
        it.at = at;
        if (to_b) q_b.push_back(it);
        else q_a.push_back(it);
    endtask

    // Called at a negedge; returns the sampling cycle of the transfer in xc
    task automatic send(input bit to_b, input logic [31:0] t, input int gap, output int xc);
        logic rdy;
        repeat (gap) @(negedge clk);
        if (to_b) begin
            iv_b = 1'b1; is_b = t[31]; ie_b = t[30:23]; im_b = t[22:0];
        end else begin
            iv_a = 1'b1; is_a = t[31]; ie_a = t[30:23]; im_a = t[22:0];
        end
        xc = -1;
        for (int k = 0; k < 20; k++) begin
            rdy = to_b ? rdy_b : rdy_a;
            if (rdy) begin
                xc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (xc < 0) chk("in_ready wait", 64'(rdy), 64'd1);
        @(negedge clk);
        if (to_b) iv_b = 1'b0;
        else iv_a = 1'b0;
    endtask

    always @(negedge clk) begin
        if (ov_a) begin
            if (q_a.size() == 0) begin
                chk("dut4 unexpected out_valid", 64'(q_a.size()), 64'd1);
            end else begin
                ea = q_a.pop_front();
                chk("dut4 sum", {os_a, oe_a, om_a, oz_a, oo_a}, {ea.v, ea.z, ea.o});
                chk("dut4 latency", 64'(cyc), 64'(ea.at));
            end
        end
    end

    always @(negedge clk) begin
        if (ov_b) begin
            if (q_b.size() == 0) begin
                chk("dut2 unexpected out_valid", 64'(q_b.size()), 64'd1);
            end else begin
                eb = q_b.pop_front();
                chk("dut2 sum", {os_b, oe_b, om_b, oz_b, oo_b}, {eb.v, eb.z, eb.o});
                chk("dut2 latency", 64'(cyc), 64'(eb.at));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout: got no finish, expected finish before time limit");
        $fatal(1, "timeout");
    end

    // dut_b frames: two terms each, then expected {s,e,m}, zero, ovf
    logic [31:0] terms_b[18] = '{
        32'h0040_0000, 32'h8040_0000,  // 1.5 + -1.5
        32'h0000_0000, 32'h7100_0000,  // 1.0 + 2^-30
        32'h0000_0000, 32'h7FC0_0000,  // 1.0 + 0.75
        32'h3FFF_FFFF, 32'h3FFF_FFFF,  // max + max
        32'h0000_0000, 32'h0000_0000,  // 1.0 + 1.0
        32'h4040_0000, 32'hC000_0000,  // 1.5*2^-128 - 2^-128
        32'h0000_0000, 32'h80C0_0000,  // 1.0 + -3.0
        32'h0000_0000, 32'hFFC0_0000,  // 1.0 + -0.75
        32'h0020_0000, 32'h8040_0000   // 1.25 + -1.5
    };
    logic [31:0] res_b[9] = '{
        32'h0000_0000, 32'h0000_0000, 32'h0060_0000, 32'h3FFF_FFFF, 32'h0080_0000,
        32'h0000_0000, 32'h8080_0000, 32'h7F00_0000, 32'hFF00_0000
    };
    logic zero_b[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic ovf_b[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    logic [15:0] rdy_pat;
    int          xfers;
    int          xc;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset outputs dut4", {ov_a, os_a, oe_a, om_a, oz_a, oo_a}, 64'd0);
        chk("reset in_ready dut4", 64'(rdy_a), 64'd1);
        chk("reset outputs dut2", {ov_b, os_b, oe_b, om_b, oz_b, oo_b}, 64'd0);
        rstn = 1'b1;
        @(negedge clk);
        chk("idle in_ready dut2", 64'(rdy_b), 64'd1);

        // 4 x 1.0 back-to-back with in_valid held high throughout
        iv_a = 1'b1; is_a = 1'b0; ie_a = 8'd0; im_a = 23'd0;
        xfers = 0;
        rdy_pat = '0;
        for (int i = 0; i < 16; i++) begin
            rdy_pat = {rdy_pat[14:0], rdy_a};
            if (rdy_a) begin
                xfers++;
                if (xfers == 4) push(1'b0, 32'h0100_0000, 1'b0, 1'b0, cyc + 4);
            end
            @(negedge clk);
        end
        iv_a = 1'b0;
        chk("in_ready pattern", 64'(rdy_pat), 64'h8888);
        repeat (3) @(negedge clk);
        chk("output hold", {ov_a, os_a, oe_a, om_a, oz_a}, {1'b0, 1'b0, 8'd2, 23'd0, 1'b0});

        // Reset mid-frame, then a fresh frame
        send(1'b0, 32'h0000_0000, 0, xc);
        send(1'b0, 32'h0000_0000, 0, xc);
        rstn = 1'b0;
        @(negedge clk);
        chk("mid-frame reset outputs", {ov_a, os_a, oe_a, om_a, oz_a, oo_a}, 64'd0);
        chk("mid-frame reset in_ready", 64'(rdy_a), 64'd1);
        rstn = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) send(1'b0, 32'h0000_0000, 0, xc);
        push(1'b0, 32'h0100_0000, 1'b0, 1'b0, xc + 4);
        for (int i = 0; i < 4; i++) send(1'b0, 32'h0000_0000, int'($urandom_range(5, 0)), xc);
        push(1'b0, 32'h0100_0000, 1'b0, 1'b0, xc + 4);

        for (int f = 0; f < 9; f++) begin
            send(1'b1, terms_b[2*f], 0, xc);
            send(1'b1, terms_b[2*f+1], 0, xc);
            push(1'b1, res_b[f], zero_b[f], ovf_b[f], xc + 4);
        end

        repeat (10) @(negedge clk);
        chk("dut4 queue drained", 64'(q_a.size()), 64'd0);
        chk("dut2 queue drained", 64'(q_b.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
